// File: rtl/loop_ctrl_pkg.sv
// Shared types for the iterative loop control stage.
package loop_ctrl_pkg;

    // Default width of the iteration count and index.
    localparam int CNT_W_DEFAULT = 8;

    // Control states.
    //   IDLE: waiting for a job.
    //   RUN : loop body is being stepped.
    //   HOLD: result is presented downstream.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } loop_state_e;

endpackage : loop_ctrl_pkg

// File: rtl/pipeline_loop_iter.sv
// Control stage for an iterative datapath. It accepts one job per input
// handshake and steps a loop body for the job's iteration count. It then
// presents the executed-iteration count and an early-exit flag on the output
// handshake. Handing off a result overlaps with accepting the next job, so
// there is no bubble between jobs.
//
// Handshake rules: a transfer happens on a rising clock edge where valid and
// ready are both 1. The cen outputs are exactly that product.
//   i_cen = i_valid && i_ready   (job capture)
//   l_cen = l_valid && l_ready   (one loop iteration)
//   the result leaves on o_valid && o_ready
// A valid output, once raised, stays up with stable payload until it is taken.
// Ready may depend combinationally on the downstream ready
// (i_ready = o_ready in HOLD).
module pipeline_loop_iter
    import loop_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [CNT_W-1:0] i_niter,
    output logic             i_cen,
    output logic             l_valid,
    input  logic             l_ready,
    output logic             l_cen,
    output logic [CNT_W-1:0] l_iter,
    output logic             l_first,
    output logic             l_last,
    input  logic             l_exit,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_early,
    output logic [CNT_W-1:0] o_iters,
    output loop_state_e      o_dbg_state
);

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    loop_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] iters_q, iters_d;
    logic             early_q, early_d;
    logic             cnt_at_last;

    assign cnt_at_last = (cnt_q == last_q);

    // Handshake outputs: a function of state and inputs only, all forced low in reset.
    always_comb begin
        i_ready = 1'b0;
        l_valid = 1'b0;
        o_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    i_ready = 1'b1;
                RUN:     l_valid = 1'b1;
                HOLD: begin
                    o_valid = 1'b1;
                    i_ready = o_ready;
                end
                default: i_ready = 1'b0;
            endcase
        end
        i_cen   = i_valid && i_ready;
        l_cen   = l_valid && l_ready;
        l_iter  = cnt_q;
        l_first = l_valid && (cnt_q == ZERO);
        l_last  = l_valid && cnt_at_last;
    end

    assign o_iters     = iters_q;
    assign o_early     = early_q;
    assign o_dbg_state = state_q;

    // Next-state logic for the FSM, the iteration counter and the result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        iters_d = iters_q;
        early_d = early_q;
        case (state_q)
            IDLE, HOLD: begin
                if (i_cen) begin
                    // A new job; in HOLD the old result leaves on this same edge.
                    if (i_niter != ZERO) begin
                        state_d = RUN;
                        cnt_d   = ZERO;
                        last_d  = i_niter - ONE;
                        early_d = 1'b0;
                    end else begin
                        // Zero iterations: report straight away, datapath passes through.
                        state_d = HOLD;
                        iters_d = ZERO;
                        early_d = 1'b0;
                    end
                end else if (state_q == HOLD && o_ready) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (l_cen) begin
                    if (cnt_at_last || l_exit) begin
                        // cnt never exceeds all-ones minus 1, so cnt+1 cannot wrap.
                        state_d = HOLD;
                        iters_d = cnt_q + ONE;
                        early_d = l_exit && !cnt_at_last;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous reset; reset drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= ZERO;
            last_q  <= ZERO;
            iters_q <= ZERO;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            iters_q <= iters_d;
            early_q <= early_d;
        end
    end

endmodule : pipeline_loop_iter

// File: tb/tb_pipeline_loop_iter.sv
// Bench for pipeline_loop_iter built with a 4-bit iteration count.
module tb_pipeline_loop_iter;
    import loop_ctrl_pkg::*;

    localparam int W = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [W-1:0] i_niter = '0;
    logic         i_cen;
    logic         l_valid;
    logic         l_ready = 1'b1;
    logic         l_cen;
    logic [W-1:0] l_iter;
    logic         l_first;
    logic         l_last;
    logic         l_exit;
    logic         o_valid;
    logic         o_ready = 1'b1;
    logic         o_early;
    logic [W-1:0] o_iters;
    loop_state_e  dbg_state;

    // The loop body requests exit on the chosen iteration of the active job.
    logic         act_exit_en  = 1'b0;
    logic [W-1:0] act_exit_idx = '0;
    assign l_exit = act_exit_en && l_valid && (l_iter == act_exit_idx);

    pipeline_loop_iter #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_niter     (i_niter),
        .i_cen       (i_cen),
        .l_valid     (l_valid),
        .l_ready     (l_ready),
        .l_cen       (l_cen),
        .l_iter      (l_iter),
        .l_first     (l_first),
        .l_last      (l_last),
        .l_exit      (l_exit),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_early     (o_early),
        .o_iters     (o_iters),
        .o_dbg_state (dbg_state)
    );

    // Scoreboard: {early, iters} expected per job, in acceptance order
    logic [W:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int lcen_cnt = 0;
    int ov_cnt = 0;
    logic [W-1:0] last_liter = '0;
    logic [W-1:0] exp_iter = '0;
    logic [W-1:0] cur_n = '0;
    logic [W:0]   mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, checks loop indices and pops results
    always @(negedge clk) begin
        if (rst) begin
            exp_iter = '0;
        end else begin
            if (i_cen) begin
                cur_n    = i_niter;
                exp_iter = '0;
            end
            if (l_cen) begin
                chk("l_iter", l_iter, exp_iter);
                chk("l_first", l_first, exp_iter == 0);
                chk("l_last", l_last, exp_iter == cur_n - 1);
                last_liter = l_iter;
                lcen_cnt++;
                exp_iter++;
            end
            if (o_valid) ov_cnt++;
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("o_iters", o_iters, mon_e[W-1:0]);
                    chk("o_early", o_early, mon_e[W]);
                end
            end
        end
    end

    // Driver: offers one job and returns one cycle after it is accepted
    task automatic send_job(input int n, input int ex, input bit keep, input bit rnd, input bit b2b);
        logic [W:0] e;
        bit got;
        if (n == 0)      e = '0;
        else if (ex < n) e = {(ex != n - 1), W'(ex + 1)};
        else             e = {1'b0, W'(n)};
        exp_q.push_back(e);
        i_valid = 1'b1;
        i_niter = W'(n);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            #1;
            if (i_cen) begin
                got = 1'b1;
                if (b2b) chk("b2b_overlap", o_valid && o_ready, 1);
                act_exit_en  = (ex < n);
                act_exit_idx = W'(ex);
                tick();
            end else begin
                tick();
                if (rnd) begin
                    l_ready = 1'($urandom_range(0, 1));
                    o_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
            tick();
            if (rnd) begin
                l_ready = 1'($urandom_range(0, 1));
                o_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("drain_timeout", exp_q.size(), 0);
        l_ready = 1'b1;
        o_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int ex;
        // Reset
        rst = 1'b1;
        tick();
        chk("rst_i_ready", i_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_l_valid", l_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_state", dbg_state, IDLE);
        chk("post_rst_i_ready", i_ready, 1);
        chk("post_rst_o_iters", o_iters, 0);
        chk("post_rst_o_early", o_early, 0);

        // 1: reset during a job drops it silently
        base = lcen_cnt;
        send_job(5, 99, 0, 0, 0);
        for (int k = 0; k < 20 && lcen_cnt - base < 2; k++) tick();
        chk("mid_iters_done", lcen_cnt - base, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_i_ready", i_ready, 0);
        chk("mid_rst_l_cen", l_cen, 0);
        chk("mid_rst_o_valid", o_valid, 0);
        base = ov_cnt;
        tick();
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_state", dbg_state, IDLE);
        chk("mid_rst_i_ready_after", i_ready, 1);
        repeat (10) tick();
        chk("mid_rst_no_o_valid", ov_cnt - base, 0);

        // 2: nominal four-iteration job, latency and one-cycle result
        send_job(4, 99, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("nom_l_valid", l_valid, 1);
            chk("nom_o_valid_low", o_valid, 0);
            tick();
        end
        chk("nom_o_valid", o_valid, 1);
        chk("nom_o_iters", o_iters, 4);
        chk("nom_o_early", o_early, 0);
        tick();
        chk("nom_o_valid_drop", o_valid, 0);

        // 3: loop-body and output backpressure
        o_ready = 1'b0;
        base = lcen_cnt;
        send_job(3, 99, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            l_ready = (k % 2 == 0);
            tick();
        end
        l_ready = 1'b1;
        chk("bp_lcen_pulses", lcen_cnt - base, 3);
        for (int k = 0; k < 4; k++) begin
            chk("bp_o_valid_held", o_valid, 1);
            chk("bp_o_iters_stable", o_iters, 3);
            tick();
        end
        o_ready = 1'b1;
        drain(0);

        // 4: early exit and exit on the final iteration
        send_job(10, 2, 0, 0, 0);
        drain(0);
        send_job(10, 9, 0, 0, 0);
        drain(0);

        // 5: zero iterations and the largest count
        base = lcen_cnt;
        send_job(0, 99, 0, 0, 0);
        chk("zero_o_valid", o_valid, 1);
        chk("zero_o_iters", o_iters, 0);
        drain(0);
        chk("zero_no_lcen", lcen_cnt - base, 0);
        base = lcen_cnt;
        send_job(15, 99, 0, 0, 0);
        drain(0);
        chk("max_lcen", lcen_cnt - base, 15);
        chk("max_last_iter", last_liter, 14);

        // 6: back-to-back jobs with i_valid held high
        send_job(2, 99, 1, 0, 0);
        send_job(0, 99, 1, 0, 1);
        send_job(3, 99, 0, 0, 1);
        drain(0);

        // Random jobs, exits and backpressure
        for (int j = 0; j < 25; j++) begin
            n  = $urandom_range(0, 15);
            ex = $urandom_range(0, 20);
            send_job(n, ex, 1'($urandom_range(0, 1)), 1, 0);
        end
        i_valid = 1'b0;
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipeline_loop_iter
